hex_scan_ctrl: RTL
==================

// Module: hex_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a bank of common-anode 7-seg digits.
//  Accepts a packed hex value over a valid/ready handshake. Sequences one
//  digit at a time: active-low anode select plus the nibble for the per-digit
//  hex decoder. Inserts an all-off guard gap between digits (anti-ghosting).
//  Applies new values only at frame boundaries (no tearing).
//  Sits between the datapath result register and the shared hex decoder.
// PARAMETERS
//  DIGITS  4      number of digits scanned; legal range 1..8
//  DWELL   50000  cycles each digit is driven; >=1
//  GUARD   500    cycles all anodes are off after each digit, and in INIT; >=1
// PORTS
//  Clk         in   1          system clock, all flops on posedge
//  Reset_n     in   1          asynchronous, active-low reset
//  Value       in   4*DIGITS   packed nibbles; digit i = Value[4i+3:4i], digit 0 = LSD
//  Load_Valid  in   1          Value is valid this cycle
//  Load_Ready  out  1          controller can accept; = !pending (combinational)
//  Digit_Sel   out  DIGITS     active-low anode enables, registered
//  Nibble      out  4          nibble for the hex decoder, registered
//  Frame_Done  out  1          1-cycle pulse at each frame boundary, registered
// BEHAVIOUR
//  Reset (async, Reset_n=0):
//   - state=INIT, digit idx=0, counter=0
//   - shadow=0, pending=0, buffer=0
//   - outputs: Digit_Sel=all 1, Nibble=0, Frame_Done=0; Load_Ready=1
//   - reset mid-scan aborts immediately; any pending value is discarded
//  FSM states: INIT -> DRIVE(idx) -> GUARD(idx) -> DRIVE(idx+1) ...
//   - GUARD(DIGITS-1) -> DRIVE(0); idx wraps
//   - outputs reflect the current state; all outputs update on the transition edge
//   - INIT:     GUARD cycles; Digit_Sel=all 1
//   - DRIVE(i): DWELL cycles; Digit_Sel bit i=0, other bits 1;
//               Nibble=shadow[4i+3:4i]
//   - GUARD(i): GUARD cycles; Digit_Sel=all 1; Nibble holds last value
//   - frame period = DIGITS*(DWELL+GUARD) cycles; never stalls
//  Dwell counter:
//   - width $clog2(max(DWELL,GUARD)+1)
//   - counts 0..N-1, clears on each state change
//  Handshake:
//   - accept when Load_Valid && Load_Ready: buffer<=Value, pending<=1
//   - Value is ignored when Load_Ready=0; the source must hold or retry
//  Frame boundary = edge leaving INIT or leaving GUARD(DIGITS-1):
//   - if pending: shadow<=buffer, pending<=0 on that edge, so DRIVE(0) of the
//     new frame shows the new value
//   - Frame_Done=1 for exactly the first DRIVE(0) cycle; the first boundary
//     after reset (leaving INIT) also pulses
//   - accept and boundary in the same cycle (pending was 0): new data lands in
//     buffer; shadow is unchanged until the next boundary
//   - Load_Ready rises the cycle after the transfer
//   - shadow is never written outside a frame boundary
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN
//   - defined: in DRIVE(i), i>0, if shadow nibbles i..DIGITS-1 are all zero,
//     Digit_Sel stays all 1 (digit dark). Nibble and timing are unchanged.
//     Digit 0 is always lit.
//   - undefined: every digit is lit in its DRIVE slot, including leading zeros
// TESTING  (DIGITS=4, DWELL=4, GUARD=1; frame = 20 cycles)
//  1. Reset, release -> Digit_Sel=4'b1111 for 1 cycle, then 4'b1110 with
//     Nibble=0 for 4 cycles and Frame_Done=1 on the first of them, then
//     4'b1111 for 1 cycle, then 4'b1101.
//  2. Load 16'hA5C3 mid-frame -> Load_Ready=0 the next cycle. Next frame shows
//     Nibble 3,C,5,A on anodes 1110,1101,1011,0111. Load_Ready=1 the cycle
//     after the Frame_Done pulse.
//  3. Load 16'h1234 (accepted), then hold Load_Valid with 16'hFFFF while
//     Load_Ready=0 -> next frame shows 4,3,2,1. 16'hFFFF is accepted only once
//     ready returns and is displayed one frame later.
//  4. Load_Valid with 16'h0007 in the exact Frame_Done cycle, pending=0 ->
//     the current frame keeps the old value; 7 is shown from the following frame.
//  5. Assert Reset_n=0 during DRIVE(2) with a load pending -> Digit_Sel=4'b1111
//     and Load_Ready=1 immediately. After release, shadow=0 (pending discarded).
//  6. LEADING_ZERO_BLANK_EN, value 16'h0040 -> anodes 1110, 1101, then 1111 in
//     the digit 2 and 3 slots. Value 16'h0000 -> only digit 0 lit. Without the
//     macro, all 4 digits light.

Source files
------------

// File: rtl/hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hex_scan_ctrl
// Purpose  : Time-multiplexed 7-seg anode scanner with guard gaps between
//            digits and value updates applied only at frame boundaries.
//            Optional: LEADING_ZERO_BLANK_EN darkens leading-zero digits.
// Revision : 1.0 - initial release
// ============================================================================
module hex_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 50000,
  parameter int GUARD  = 500
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [4*DIGITS-1:0]   Value,
  input  logic                  Load_Valid,
  output logic                  Load_Ready,
  output logic [DIGITS-1:0]     Digit_Sel,
  output logic [3:0]            Nibble,
  output logic                  Frame_Done
);

  localparam int c_MAXN  = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int c_CNT_W = $clog2(c_MAXN + 1);
  localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL - 1);
  localparam logic [c_CNT_W-1:0] c_GUARD_LAST = c_CNT_W'(GUARD - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_IDX_W-1:0]    r_idx;
  logic [c_IDX_W-1:0]    w_idx_nxt;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_CNT_W-1:0]    w_cnt_nxt;
  logic [4*DIGITS-1:0]   r_shadow;
  logic [4*DIGITS-1:0]   w_shadow_nxt;
  logic [4*DIGITS-1:0]   r_buffer;
  logic [4*DIGITS-1:0]   w_buffer_nxt;
  logic                  r_pending;
  logic                  w_pending_nxt;
  logic                  w_boundary;
  logic                  w_accept;
  logic [DIGITS-1:0]     w_sel_nxt;
  logic [3:0]            w_nib_nxt;
  logic [DIGITS-1:0]     w_lit;

  assign Load_Ready = ~r_pending;
  assign w_accept   = Load_Valid & ~r_pending;

  // Sequencer: INIT -> DRIVE(0) -> GUARD(0) -> DRIVE(1) ... -> GUARD(last) -> DRIVE(0)
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + c_CNT_W'(1);
    w_boundary  = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_cnt == c_GUARD_LAST) begin
          w_state_nxt = ST_DRIVE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_boundary  = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == c_DWELL_LAST) begin
          w_state_nxt = ST_GUARD;
          w_cnt_nxt   = '0;
        end
      end
      ST_GUARD: begin
        if (r_cnt == c_GUARD_LAST) begin
          w_state_nxt = ST_DRIVE;
          w_cnt_nxt   = '0;
          if (r_idx == c_IDX_LAST) begin
            w_idx_nxt  = '0;
            w_boundary = 1'b1;
          end else begin
            w_idx_nxt  = r_idx + c_IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A transfer at the boundary and a new accept are mutually exclusive,
  // since an accept requires pending to be clear.
  always_comb begin
    w_shadow_nxt  = r_shadow;
    w_buffer_nxt  = r_buffer;
    w_pending_nxt = r_pending;
    if (w_boundary && r_pending) begin
      w_shadow_nxt  = r_buffer;
      w_pending_nxt = 1'b0;
    end
    if (w_accept) begin
      w_buffer_nxt  = Value;
      w_pending_nxt = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i is lit unless it and every more-significant nibble are zero.
  always_comb begin
    w_lit    = '1;
    for (int i = 1; i < DIGITS; i++) begin
      w_lit[i] = ((w_shadow_nxt >> (4 * i)) != '0);
    end
  end
`else
  assign w_lit = '1;
`endif

  // Outputs are computed from the next state so they change on the transition edge.
  always_comb begin
    w_sel_nxt = '1;
    w_nib_nxt = Nibble;
    if (w_state_nxt == ST_DRIVE) begin
      w_nib_nxt = w_shadow_nxt[4*w_idx_nxt +: 4];
      if (w_lit[w_idx_nxt]) begin
        w_sel_nxt[w_idx_nxt] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= ST_INIT;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_shadow   <= '0;
      r_buffer   <= '0;
      r_pending  <= 1'b0;
      Digit_Sel  <= '1;
      Nibble     <= 4'h0;
      Frame_Done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shadow   <= w_shadow_nxt;
      r_buffer   <= w_buffer_nxt;
      r_pending  <= w_pending_nxt;
      Digit_Sel  <= w_sel_nxt;
      Nibble     <= w_nib_nxt;
      Frame_Done <= w_boundary;
    end
  end

endmodule
`default_nettype wire
